// File: rtl/mac_sequencer.sv
// mac_sequencer: fills two operand FIFOs with a fixed pattern, then streams them into an external MAC.
module mac_sequencer #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLOCK_50,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  fifo_a_full,
  input  logic                  fifo_b_full,
  input  logic                  fifo_a_empty,
  input  logic                  fifo_b_empty,
  output logic                  wren,
  output logic [DATA_WIDTH-1:0] wdata_a,
  output logic [DATA_WIDTH-1:0] wdata_b,
  output logic                  rden,
  output logic                  mac_en,
  output logic                  mac_clr,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, EXEC = 2'd2, DONE = 2'd3} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic mac_en_q, mac_en_d, mac_clr_q, mac_clr_d;
  logic launch;
  always_comb begin
    launch    = (state_q == IDLE || state_q == DONE) && start;
    wren      = state_q == FILL && !fifo_a_full && !fifo_b_full && wr_cnt_q < DEPTH_C;
    rden      = state_q == EXEC && !fifo_a_empty && !fifo_b_empty && rd_cnt_q < DEPTH_C;
    wdata_a   = state_q == FILL ? DATA_WIDTH'(32'(wr_cnt_q) + 32'd1) : '0;
    wdata_b   = state_q == FILL ? DATA_WIDTH'(32'(DEPTH) - 32'(wr_cnt_q)) : '0;
    mac_en_d  = rden;
    mac_clr_d = launch;
    wr_cnt_d  = launch ? '0 : wren ? wr_cnt_q + 1'b1 : wr_cnt_q;
    rd_cnt_d  = launch ? '0 : rden ? rd_cnt_q + 1'b1 : rd_cnt_q;
    state_d   = state_q;
    if (launch) state_d = FILL;
    else if (wren && wr_cnt_q == DEPTH_C - 1'b1) state_d = EXEC;
    // rd_cnt first equals DEPTH in the cycle carrying the final mac_en pulse
    else if (state_q == EXEC && rd_cnt_q == DEPTH_C) state_d = DONE;
  end
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state_q   <= IDLE;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      mac_en_q  <= 1'b0;
      mac_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      mac_en_q  <= mac_en_d;
      mac_clr_q <= mac_clr_d;
    end
  end
  assign mac_en  = mac_en_q;
  assign mac_clr = mac_clr_q;
  assign busy    = state_q == FILL || state_q == EXEC;
  assign done    = state_q == DONE;
  assign state   = state_q;
endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: directed runs checked each cycle against a behavioural model plus literal run timings.
module tb_mac_sequencer;
  localparam int DEPTH = 8;
  localparam int DW = 8;
  logic clk = 0, rst = 1, start = 0, af = 0, bf = 0, ae = 0, be = 0;
  logic wren, rden, mac_en, mac_clr, busy, done;
  logic [DW-1:0] wa, wb;
  logic [1:0] state;
  int errs = 0, checks = 0;
  bit chk_on = 0;
  int m_mode = 0, m_w = 0, m_r = 0;
  bit m_men = 0, m_clr = 0;
  logic e_wren, e_rden;
  logic [DW-1:0] e_wa, e_wb;
  logic [DW-1:0] qa[$], qb[$];
  logic [DW-1:0] fa = 0, fb = 0;
  int acc = 0;
  int d, nw, nm, ca;

  always #10 clk = ~clk;

  mac_sequencer #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .CLOCK_50(clk), .RST(rst), .start(start),
    .fifo_a_full(af), .fifo_b_full(bf), .fifo_a_empty(ae), .fifo_b_empty(be),
    .wren(wren), .wdata_a(wa), .wdata_b(wb), .rden(rden), .mac_en(mac_en),
    .mac_clr(mac_clr), .busy(busy), .done(done), .state(state)
  );

  always_comb begin
    e_wren = m_mode == 1 && !af && !bf && m_w < DEPTH;
    e_rden = m_mode == 2 && !ae && !be && m_r < DEPTH;
    e_wa   = m_mode == 1 ? DW'(m_w + 1) : '0;
    e_wb   = m_mode == 1 ? DW'(DEPTH - m_w) : '0;
  end

  // model of the sequencer plus the surrounding FIFOs and MAC
  always @(posedge clk) begin
    bit wr, rd, go;
    wr = e_wren;
    rd = e_rden;
    go = (m_mode == 0 || m_mode == 3) && start;
    if (rst) begin
      m_mode = 0; m_w = 0; m_r = 0; m_men = 0; m_clr = 0;
      qa.delete(); qb.delete(); fa = 0; fb = 0;
    end else begin
      m_men = rd;
      m_clr = go;
      if (go) begin m_mode = 1; m_w = 0; m_r = 0; end
      else if (m_mode == 1 && wr) begin m_w++; if (m_w == DEPTH) m_mode = 2; end
      else if (m_mode == 2 && !rd && m_r == DEPTH) m_mode = 3;
      else if (m_mode == 2 && rd) m_r++;
      if (mac_clr) acc = 0;
      else if (mac_en) acc += int'(fa) * int'(fb);
      if (wren) begin qa.push_back(wa); qb.push_back(wb); end
      if (rden && qa.size() > 0) begin fa = qa.pop_front(); fb = qb.pop_front(); end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if ({wren, rden, mac_en, mac_clr, busy, done, state, wa, wb} !==
          {e_wren, e_rden, m_men, m_clr, m_mode == 1 || m_mode == 2, m_mode == 3, 2'(m_mode), e_wa, e_wb}) begin
        errs++;
        $display("FAIL cycle_cmp t=%0t got wren=%b rden=%b men=%b clr=%b busy=%b done=%b st=%0d wa=%0d wb=%0d want wren=%b rden=%b men=%b clr=%b st=%0d wa=%0d wb=%0d",
                 $time, wren, rden, mac_en, mac_clr, busy, done, state, wa, wb,
                 e_wren, e_rden, m_men, m_clr, m_mode, e_wa, e_wb);
      end
    end
  end

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errs++;
      $display("FAIL %s got=%0d want=%0d", n, a, e);
    end
  endtask

  task automatic run(input bit hold, input int fs, input int fe, input int es, input int ee,
                     output int done_at, output int n_w, output int n_m, output int clr_at);
    done_at = -1; n_w = 0; n_m = 0; clr_at = -1;
    @(posedge clk); #1 start = 1;
    for (int k = 1; k <= 60 && done_at < 0; k++) begin
      @(posedge clk); #1;
      start = hold;
      af = k >= fs && k <= fe;
      be = k >= es && k <= ee;
      @(negedge clk);
      if (wren) n_w++;
      if (mac_en) n_m++;
      if (mac_clr && clr_at < 0) clr_at = k;
      if (done) done_at = k;
    end
    af = 0; be = 0;
    if (done_at < 0) chk("run_timeout", 0, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_on = 1;
    @(negedge clk);
    chk("reset_state", int'(state), 0);
    chk("reset_busy", int'(busy), 0);
    run(0, 0, -1, 0, -1, d, nw, nm, ca);
    chk("nom_done_at", d, 18); chk("nom_wren_n", nw, 8); chk("nom_men_n", nm, 8);
    chk("nom_clr_at", ca, 1); chk("nom_acc", acc, 120); chk("nom_state", int'(state), 3);
    run(0, 0, -1, 0, -1, d, nw, nm, ca);
    chk("b2b_done_at", d, 18); chk("b2b_acc", acc, 120);
    run(0, 3, 5, 0, -1, d, nw, nm, ca);
    chk("full_done_at", d, 21); chk("full_wren_n", nw, 8); chk("full_acc", acc, 120);
    run(0, 0, -1, 12, 13, d, nw, nm, ca);
    chk("empty_done_at", d, 20); chk("empty_men_n", nm, 8); chk("empty_acc", acc, 120);
    run(1, 0, -1, 0, -1, d, nw, nm, ca);
    chk("hold_done_at", d, 18);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_refill_clr", int'(mac_clr), 1); chk("hold_refill_state", int'(state), 1);
    #1 start = 0;
    for (int k = 0; k < 40 && !done; k++) @(negedge clk);
    chk("hold_rerun_done", int'(done), 1); chk("hold_acc", acc, 120);
    @(posedge clk); #1 start = 1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      start = 0;
      rst = k == 12;
    end
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_mid_state", int'(state), 0);
    chk("rst_mid_outs", int'({wren, rden, mac_en, mac_clr, busy, done}), 0);
    run(0, 0, -1, 0, -1, d, nw, nm, ca);
    chk("post_rst_done_at", d, 18); chk("post_rst_clr_at", ca, 1); chk("post_rst_acc", acc, 120);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter DEPTH, default 8, operand pairs per run; this is also the FIFO depth.
REQ-002 Parameter DATA_WIDTH, default 8, operand width.
REQ-003 CLOCK_50  in  1  sole clock; all logic on the rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 start  in  1  run request, sampled only in IDLE or DONE.
REQ-006 fifo_a_full, fifo_b_full  in  1 each  full flags of operand FIFOs A/B.
REQ-007 fifo_a_empty, fifo_b_empty  in  1 each  empty flags of operand FIFOs A/B.
REQ-008 wren  out  1  write enable, common to both FIFOs.
REQ-009 wdata_a, wdata_b  out  DATA_WIDTH each  FIFO write data.
REQ-010 rden  out  1  read enable, common to both FIFOs (FIFO read latency 1).
REQ-011 mac_en  out  1  MAC accumulate enable for the current FIFO outputs.
REQ-012 mac_clr  out  1  MAC accumulator clear.
REQ-013 busy  out  1  high in FILL or EXEC.
REQ-014 done  out  1  high in DONE.
REQ-015 state  out  2  encoded state for LEDR display.

Function
REQ-016 FSM encoding SHALL be IDLE=0, FILL=1, EXEC=2, DONE=3; state output SHALL equal the encoding.
REQ-017 IDLE/DONE: start=1 -> FILL next cycle; wr_cnt and rd_cnt (each $clog2(DEPTH)+1 bits) cleared.
REQ-018 mac_clr SHALL be high exactly for the first cycle in FILL; low otherwise.
REQ-019 FILL: wren = !fifo_a_full && !fifo_b_full && (wr_cnt < DEPTH), combinational.
REQ-020 FILL: wdata_a = wr_cnt+1, wdata_b = DEPTH-wr_cnt, truncated to DATA_WIDTH; wr_cnt +1 per cycle with wren=1.
REQ-021 Either full flag high: wren low, wr_cnt holds, no data lost or skipped.
REQ-022 FILL -> EXEC on the edge where wr_cnt reaches DEPTH.
REQ-023 EXEC: rden = !fifo_a_empty && !fifo_b_empty && (rd_cnt < DEPTH); rd_cnt +1 per rden cycle.
REQ-024 mac_en SHALL be rden delayed exactly one cycle (registered), in all states.
REQ-025 Either empty flag high in EXEC: rden low, rd_cnt holds; run completes when data arrives.
REQ-026 EXEC -> DONE on the cycle after the mac_en pulse for read number DEPTH, i.e. rd_cnt==DEPTH and mac_en==0.
REQ-027 DONE: done held high until start; start in FILL or EXEC SHALL be ignored.
REQ-028 wren, rden SHALL be low outside FILL/EXEC respectively; wdata_* SHALL be 0 outside FILL.
REQ-029 No-stall latency: start sampled at cycle 0 -> wren cycles 1..DEPTH, rden cycles DEPTH+1..2*DEPTH, mac_en cycles DEPTH+2..2*DEPTH+1, done from cycle 2*DEPTH+2.

Reset
REQ-030 RST=1 at an edge -> state IDLE, counters 0, mac_en pipeline register 0, all outputs 0 next cycle, in any state.
REQ-031 RST takes priority over start and all other inputs.
REQ-032 Reset mid-run SHALL abandon the run; the sequencer SHALL NOT flush or otherwise touch the FIFOs.

Verification
REQ-033 Nominal: reset, start one cycle, flags idle -> wren cycles 1-8 with wdata_a 1..8, wdata_b 8..1; rden 9-16; mac_en 10-17; done=1, state=3 at 18; external MAC result 120.
REQ-034 Full stall: fifo_a_full=1 for cycles 3-5 of FILL -> wren low those cycles, wdata_a resumes at the held value, done delayed by exactly 3 cycles.
REQ-035 Empty stall: fifo_b_empty=1 for 2 cycles mid-EXEC -> rden low 2 cycles, mac_en gap 2 cycles, exactly 8 mac_en pulses total.
REQ-036 Reset mid-EXEC: RST at cycle 12 -> cycle 13 all outputs 0, state=0; new start -> full nominal sequence with mac_clr pulse.
REQ-037 start held high through a run -> ignored in FILL/EXEC; DONE re-enters FILL next cycle with mac_clr=1.
REQ-038 Back-to-back runs: second start in DONE -> identical output trace and MAC result 120.
